// File: rtl/tt_haz_detect_if.sv
// Issue / resolver bundle for the hazard detection front end.
// Master drives issue and resolver controls; slave returns hazard classes.
interface tt_haz_detect_if #(
    parameter int REG_W = 3
);
    logic             iss_valid;
    logic [REG_W-1:0] iss_rs1;
    logic [REG_W-1:0] iss_rs2;
    logic [REG_W-1:0] iss_rd;
    logic             iss_we;
    logic             iss_ld;
    logic             iss_st;
    logic             iss_br;
    logic             iss_pred;
    logic             br_taken;
    logic             pc_freeze;
    logic             do_flush;
    logic             iss_ready;
    logic             data;
    logic             fwrd;
    logic             str;
    logic             ctrl;
    logic             branch;
    logic             crct;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd,
        output iss_we, iss_ld, iss_st, iss_br, iss_pred,
        output br_taken, pc_freeze, do_flush,
        input  iss_ready, data, fwrd, str, ctrl, branch, crct
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd,
        input  iss_we, iss_ld, iss_st, iss_br, iss_pred,
        input  br_taken, pc_freeze, do_flush,
        output iss_ready, data, fwrd, str, ctrl, branch, crct
    );
endinterface

// File: rtl/tt_haz_detect.sv
// Hazard detection front end: tracks ID/EX/MEM slots and raises
// hazard classes for the resolver, plus saturating stall/flush counters.
module tt_haz_detect #(
    parameter int REG_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tt_haz_detect_if.slave       hz,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             ld;
        logic             st;
        logic             br;
        logic             pred;
    } slot_t;

    slot_t            r_id;
    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            w_iss;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;
    logic             w_ex_m;
    logic             w_mem_m;
    logic             w_stall_ev;

    always_comb begin
        w_iss      = '0;
        w_iss.v    = hz.iss_valid;
        w_iss.rs1  = hz.iss_rs1;
        w_iss.rs2  = hz.iss_rs2;
        w_iss.rd   = hz.iss_rd;
        w_iss.we   = hz.iss_we;
        w_iss.ld   = hz.iss_ld;
        w_iss.st   = hz.iss_st;
        w_iss.br   = hz.iss_br;
        w_iss.pred = hz.iss_pred;
    end

    assign w_stall_ev = hz.pc_freeze && !hz.do_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id  <= '0;
            r_ex  <= '0;
            r_mem <= '0;
        end else begin
            r_mem <= r_ex;
            if (hz.do_flush) begin
                r_id <= '0;
                r_ex <= '0;
            end else if (hz.pc_freeze) begin
                r_ex <= '0;
            end else begin
                r_id <= w_iss;
                r_ex <= r_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (w_stall_ev && r_stall != '1)
                r_stall <= r_stall + CNT_W'(1);
            if (hz.do_flush && r_flush != '1)
                r_flush <= r_flush + CNT_W'(1);
        end
    end

    // rd == 0 is the zero register and never produces a dependency
    assign w_ex_m  = r_ex.v && r_ex.we && (r_ex.rd != '0) &&
                     ((r_ex.rd == r_id.rs1) || (r_ex.rd == r_id.rs2));
    assign w_mem_m = r_mem.v && r_mem.we && (r_mem.rd != '0) &&
                     ((r_mem.rd == r_id.rs1) || (r_mem.rd == r_id.rs2));

    assign hz.iss_ready = !hz.pc_freeze;
    assign hz.data      = r_id.v && (w_ex_m || w_mem_m);
    assign hz.fwrd      = hz.data && !(w_ex_m && r_ex.ld);
    assign hz.str       = r_id.v && (r_id.ld || r_id.st) &&
                          r_ex.v && (r_ex.ld || r_ex.st);
    assign hz.ctrl      = (r_id.v && r_id.br) || (r_ex.v && r_ex.br);
    assign hz.branch    = r_ex.v && r_ex.br;
    assign hz.crct      = hz.branch && (hz.br_taken == r_ex.pred);

    assign stall_cnt = r_stall;
    assign flush_cnt = r_flush;
endmodule

// File: tb/tb_tt_haz_detect.sv
// Directed bench for tt_haz_detect: RAW, load-use, r0, branch,
// structural, saturation and reset scenarios.
module tb_tt_haz_detect;
    logic       clk;
    logic       rst_n;
    logic [7:0] stall_cnt;
    logic [7:0] flush_cnt;
    int         n_chk;
    int         n_pass;

    tt_haz_detect_if #(.REG_W(3)) hz ();

    tt_haz_detect #(.REG_W(3), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hz        (hz.slave),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] haz();
        return {hz.data, hz.fwrd, hz.str, hz.ctrl, hz.branch, hz.crct};
    endfunction

    task automatic iss(input logic v, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic we, input logic ld,
                       input logic st, input logic br, input logic pd);
        hz.iss_valid = v;
        hz.iss_rs1   = a;
        hz.iss_rs2   = b;
        hz.iss_rd    = d;
        hz.iss_we    = we;
        hz.iss_ld    = ld;
        hz.iss_st    = st;
        hz.iss_br    = br;
        hz.iss_pred  = pd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
        hz.pc_freeze = 1'b0;
        hz.do_flush  = 1'b0;
        hz.br_taken  = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iss(1, 1, 2, 3, 1, 0, 0, 1, 0);
        hz.pc_freeze = 1'b1;
        hz.do_flush  = 1'b0;
        hz.br_taken  = 1'b0;
        repeat (3) step();
        n_chk++;
        if (haz() !== 6'b0)
            $display("FAIL rst_haz got %b exp %b", haz(), 6'b0);
        else n_pass++;
        n_chk++;
        if (stall_cnt !== 8'd0 || flush_cnt !== 8'd0)
            $display("FAIL rst_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        else n_pass++;
        n_chk++;
        if (hz.iss_ready !== 1'b0)
            $display("FAIL rst_ready_frz got %b exp 0", hz.iss_ready);
        else n_pass++;
        idle(0);
        #1;
        n_chk++;
        if (hz.iss_ready !== 1'b1)
            $display("FAIL rst_ready got %b exp 1", hz.iss_ready);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_chk++;
        if (haz() !== 6'b0)
            $display("FAIL rst_post got %b exp %b", haz(), 6'b0);
        else n_pass++;
    endtask

    task automatic test_fwd_raw();
        idle(3);
        iss(1, 1, 2, 3, 1, 0, 0, 0, 0);
        step();
        iss(1, 3, 5, 4, 1, 0, 0, 0, 0);
        step();
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (haz() !== 6'b110000)
            $display("FAIL raw_ex got %b exp %b", haz(), 6'b110000);
        else n_pass++;
        step();
        n_chk++;
        if (hz.data !== 1'b0)
            $display("FAIL raw_drain got %b exp 0", hz.data);
        else n_pass++;
    endtask

    task automatic test_load_use();
        idle(3);
        iss(1, 0, 0, 3, 1, 1, 0, 0, 0);
        step();
        iss(1, 3, 1, 4, 1, 0, 0, 0, 0);
        step();
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (haz() !== 6'b100000)
            $display("FAIL lu_ex got %b exp %b", haz(), 6'b100000);
        else n_pass++;
        hz.pc_freeze = 1'b1;
        #1;
        n_chk++;
        if (hz.iss_ready !== 1'b0)
            $display("FAIL lu_ready got %b exp 0", hz.iss_ready);
        else n_pass++;
        step();
        hz.pc_freeze = 1'b0;
        n_chk++;
        if (haz() !== 6'b110000)
            $display("FAIL lu_mem got %b exp %b", haz(), 6'b110000);
        else n_pass++;
        n_chk++;
        if (stall_cnt !== 8'd1)
            $display("FAIL lu_stall got %0d exp 1", stall_cnt);
        else n_pass++;
        step();
        n_chk++;
        if (hz.data !== 1'b0)
            $display("FAIL lu_drain got %b exp 0", hz.data);
        else n_pass++;
    endtask

    task automatic test_r0();
        idle(3);
        iss(1, 1, 2, 0, 1, 0, 0, 0, 0);
        step();
        iss(1, 0, 0, 5, 1, 0, 0, 0, 0);
        step();
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (hz.data !== 1'b0)
            $display("FAIL r0_ex got %b exp 0", hz.data);
        else n_pass++;
        step();
        n_chk++;
        if (hz.data !== 1'b0)
            $display("FAIL r0_mem got %b exp 0", hz.data);
        else n_pass++;
    endtask

    task automatic test_branch(input logic tk, input logic [7:0] fexp);
        logic exp_c;
        exp_c = (tk == 1'b0);
        idle(3);
        iss(1, 1, 2, 0, 0, 0, 0, 1, 0);
        step();
        iss(1, 1, 2, 6, 1, 0, 0, 0, 0);
        hz.br_taken = 1'b0;
        #1;
        n_chk++;
        if (haz() !== 6'b000100)
            $display("FAIL br_id got %b exp %b", haz(), 6'b000100);
        else n_pass++;
        step();
        hz.br_taken = tk;
        #1;
        n_chk++;
        if (haz() !== {3'b000, 2'b11, exp_c})
            $display("FAIL br_ex tk=%b got %b exp %b", tk, haz(),
                     {3'b000, 2'b11, exp_c});
        else n_pass++;
        hz.do_flush = 1'b1;
        iss(1, 1, 2, 0, 0, 0, 0, 1, 0);
        step();
        hz.do_flush = 1'b0;
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (haz() !== 6'b0)
            $display("FAIL br_flush got %b exp %b", haz(), 6'b0);
        else n_pass++;
        n_chk++;
        if (flush_cnt !== fexp)
            $display("FAIL br_fcnt got %0d exp %0d", flush_cnt, fexp);
        else n_pass++;
        n_chk++;
        if (stall_cnt !== 8'd1)
            $display("FAIL br_scnt got %0d exp 1", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_struct();
        idle(3);
        iss(1, 1, 2, 0, 0, 0, 1, 0, 0);
        step();
        iss(1, 1, 0, 2, 1, 1, 0, 0, 0);
        step();
        iss(1, 4, 0, 5, 1, 1, 0, 0, 0);
        n_chk++;
        if (hz.str !== 1'b1)
            $display("FAIL st_ld got %b exp 1", hz.str);
        else n_pass++;
        step();
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (hz.str !== 1'b1)
            $display("FAIL ld_ld got %b exp 1", hz.str);
        else n_pass++;
        idle(3);
        iss(1, 1, 2, 0, 0, 0, 1, 0, 0);
        step();
        iss(1, 1, 1, 6, 1, 0, 0, 0, 0);
        step();
        iss(1, 7, 0, 5, 1, 1, 0, 0, 0);
        step();
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (hz.str !== 1'b0)
            $display("FAIL st_mem got %b exp 0", hz.str);
        else n_pass++;
    endtask

    task automatic test_saturation();
        idle(2);
        hz.pc_freeze = 1'b1;
        repeat (300) step();
        n_chk++;
        if (stall_cnt !== 8'd255)
            $display("FAIL sat_stall got %0d exp 255", stall_cnt);
        else n_pass++;
        repeat (2) step();
        hz.pc_freeze = 1'b0;
        n_chk++;
        if (stall_cnt !== 8'd255)
            $display("FAIL sat_hold got %0d exp 255", stall_cnt);
        else n_pass++;
        n_chk++;
        if (flush_cnt !== 8'd2)
            $display("FAIL sat_fcnt got %0d exp 2", flush_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle(3);
        iss(1, 1, 2, 3, 1, 0, 0, 0, 0);
        step();
        iss(1, 3, 0, 0, 0, 0, 0, 1, 1);
        step();
        iss(1, 0, 0, 2, 1, 1, 0, 0, 0);
        n_chk++;
        if (haz() !== 6'b110100)
            $display("FAIL mid_pre got %b exp %b", haz(), 6'b110100);
        else n_pass++;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (haz() !== 6'b0)
            $display("FAIL mid_rst got %b exp %b", haz(), 6'b0);
        else n_pass++;
        n_chk++;
        if (stall_cnt !== 8'd0 || flush_cnt !== 8'd0)
            $display("FAIL mid_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        else n_pass++;
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        n_chk++;
        if (haz() !== 6'b0)
            $display("FAIL mid_post got %b exp %b", haz(), 6'b0);
        else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_fwd_raw();
        test_load_use();
        test_r0();
        test_branch(1'b1, 8'd1);
        test_branch(1'b0, 8'd2);
        test_struct();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
